// File: rtl/qwb_pkg.sv
// Shared types and parameter helpers for the quantized-row SRAM writeback block.
package qwb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // SRAM words needed to carry one quantized row.
    function automatic int words_per_row(input int row_bits, input int word_bits);
        return row_bits / word_bits;
    endfunction

    // A row must split into a whole, non-zero number of SRAM words.
    function automatic bit row_split_ok(input int row_bits, input int word_bits);
        return (word_bits > 0) && (row_bits >= word_bits) && ((row_bits % word_bits) == 0);
    endfunction

endpackage

// File: rtl/qwb_row_fifo.sv
// Synchronous row buffer with push/pop, full/empty and a look-ahead head word.
// Caller must not push when full or pop when empty.
module qwb_row_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;

    assign full  = (count == (AW + 1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/quant_writeback.sv
// Serializes quantized rows into consecutive SRAM words, one job per start pulse.
// Optional sticky protocol-error output enabled by defining QWB_ERR_EN.
module quant_writeback
    import qwb_pkg::*;
#(
    parameter int ARRAY_SIZE        = 8,
    parameter int OUTPUT_DATA_WIDTH = 16,
    parameter int SRAM_DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH        = 10,
    parameter int CNT_WIDTH         = 10,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [ADDR_WIDTH-1:0]                 base_addr,
    input  logic [CNT_WIDTH-1:0]                  row_count,
    input  logic                                  in_valid,
    input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] in_data,
    output logic                                  in_ready,
    output logic                                  sram_wen,
    output logic [ADDR_WIDTH-1:0]                 sram_waddr,
    output logic [SRAM_DATA_WIDTH-1:0]            sram_wdata,
    output logic                                  busy,
    output logic                                  done
`ifdef QWB_ERR_EN
    ,
    output logic                                  err
`endif
);
    localparam int ROW_W  = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
    localparam int W      = words_per_row(ROW_W, SRAM_DATA_WIDTH);
    localparam int WIDX_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [WIDX_W-1:0]     LAST_IDX = WIDX_W'(W - 1);
    localparam logic [WIDX_W-1:0]     WIDX_ONE = WIDX_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

    if (!row_split_ok(ROW_W, SRAM_DATA_WIDTH)) begin : g_bad_split
        $error("quant_writeback: row width must be a non-zero multiple of SRAM_DATA_WIDTH");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("quant_writeback: FIFO_DEPTH must be a power of two and at least 2");
    end

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [CNT_WIDTH-1:0]  rc;
    logic [CNT_WIDTH-1:0]  rows_acc;
    logic [CNT_WIDTH-1:0]  rows_out;
    logic [WIDX_W-1:0]     widx;
    logic [ROW_W-1:0]      row_reg;

    logic             fifo_full;
    logic             fifo_empty;
    logic [ROW_W-1:0] fifo_head;
    logic             accept;
    logic             ser_idle;
    logic             take_new;
    logic             pop;
    logic             bypass;
    logic             push;
    logic             load_row;
    logic             job_end;
    logic [ROW_W-1:0] new_row;

    assign in_ready = (state == RUN) && !fifo_full && (rows_acc < rc);
    assign accept   = in_valid && in_ready;

    // The serializer is free when nothing is on the port or the last word of a row is.
    assign ser_idle = !sram_wen || (widx == LAST_IDX);
    assign take_new = (state == RUN) && ser_idle;
    assign pop      = take_new && !fifo_empty;
    // An empty FIFO lets an incoming row skip straight to the output register.
    assign bypass   = take_new && fifo_empty && accept;
    assign push     = accept && !bypass;
    assign load_row = pop || bypass;
    assign new_row  = pop ? fifo_head : in_data;
    assign job_end  = sram_wen && (widx == LAST_IDX) && (rows_out == (rc - CNT_ONE));

    qwb_row_fifo #(
        .WIDTH(ROW_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(in_data),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            sram_wen   <= 1'b0;
            sram_waddr <= '0;
            sram_wdata <= '0;
            addr       <= '0;
            rc         <= '0;
            rows_acc   <= '0;
            rows_out   <= '0;
            widx       <= '0;
            row_reg    <= '0;
        end else begin
            done     <= 1'b0;
            sram_wen <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr     <= base_addr;
                        rc       <= row_count;
                        rows_acc <= '0;
                        rows_out <= '0;
                        widx     <= '0;
                        busy     <= 1'b1;
                        if (row_count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        rows_acc <= rows_acc + CNT_ONE;
                    end
                    if (load_row) begin
                        sram_wen   <= 1'b1;
                        sram_waddr <= addr;
                        sram_wdata <= new_row[SRAM_DATA_WIDTH-1:0];
                        row_reg    <= new_row >> SRAM_DATA_WIDTH;
                        widx       <= '0;
                        addr       <= addr + ADDR_ONE;
                    end else if (!ser_idle) begin
                        sram_wen   <= 1'b1;
                        sram_waddr <= addr;
                        sram_wdata <= row_reg[SRAM_DATA_WIDTH-1:0];
                        row_reg    <= row_reg >> SRAM_DATA_WIDTH;
                        widx       <= widx + WIDX_ONE;
                        addr       <= addr + ADDR_ONE;
                    end
                    if (sram_wen && (widx == LAST_IDX)) begin
                        rows_out <= rows_out + CNT_ONE;
                    end
                    if (job_end) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef QWB_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((in_valid && (state != RUN)) || (start && busy)) begin
            err <= 1'b1;
        end else if (start && (state == IDLE)) begin
            err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_quant_writeback.sv
// Bench for quant_writeback: random jobs against a word-schedule model, plus literal write checks.
module tb_quant_writeback;
    localparam int AS = 8, ODW = 16, SDW = 32, AW = 10, CW = 10, DEPTH = 4;
    localparam int ROW_W = AS * ODW;
    localparam int W = ROW_W / SDW;
    localparam int BIG = 1 << 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] row_count = '0;
    logic in_valid = 1'b0;
    logic [ROW_W-1:0] in_data = '0;
    logic in_ready, sram_wen, busy, done;
    logic [AW-1:0] sram_waddr;
    logic [SDW-1:0] sram_wdata;
`ifdef QWB_ERR_EN
    logic err;
`endif

    quant_writeback #(
        .ARRAY_SIZE(AS), .OUTPUT_DATA_WIDTH(ODW), .SRAM_DATA_WIDTH(SDW),
        .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .row_count(row_count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .sram_wen(sram_wen), .sram_waddr(sram_waddr), .sram_wdata(sram_wdata),
        .busy(busy), .done(done)
`ifdef QWB_ERR_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Model: every accepted row schedules W words as early as the write port allows.
    typedef struct { int t; logic [AW-1:0] a; logic [SDW-1:0] d; } word_t;
    typedef struct { int acc; int first; } rrow_t;
    word_t wq[$];
    rrow_t rq[$];
    int busy_from = BIG, done_cycle = -1, last_emit = 0, macc = 0, mrc = 0;
    logic [AW-1:0] maddr = '0;
    bit armed = 0;

    int log_n = 0, wen_cnt = 0, busy_cnt = 0, done_seen = 0;
    logic [AW-1:0] log_a [64];
    logic [SDW-1:0] log_d [64];
    int log_c [64];

    always @(negedge clk) begin
        int c, occ, t0;
        bit ew, eb, ed, er, run;
        logic [ROW_W-1:0] row;
        c = cyc;
        if (armed) begin
            ew  = (wq.size() > 0) && (wq[0].t == c);
            eb  = (busy_from <= c) && (c <= done_cycle);
            ed  = (c == done_cycle);
            run = (busy_from <= c) && (c < done_cycle);
            occ = 0;
            foreach (rq[i]) if (rq[i].acc < c && rq[i].first > c) occ++;
            er = run && (macc < mrc) && (occ < DEPTH);
            chk("sram_wen", sram_wen, ew);
            chk("in_ready", in_ready, er);
            chk("busy", busy, eb);
            chk("done", done, ed);
            if (ew) begin
                chk("sram_waddr", sram_waddr, wq[0].a);
                chk("sram_wdata", sram_wdata, wq[0].d);
            end
            if (sram_wen) begin
                if (log_n < 64) begin
                    log_a[log_n] = sram_waddr;
                    log_d[log_n] = sram_wdata;
                    log_c[log_n] = c;
                    log_n++;
                end
                wen_cnt++;
            end
            if (busy) busy_cnt++;
            if (done) done_seen++;

            if (rst) begin
                wq.delete();
                rq.delete();
                busy_from = BIG;
                done_cycle = -1;
            end else begin
                if (wq.size() > 0 && wq[0].t <= c) void'(wq.pop_front());
                while (rq.size() > 0 && rq[0].first <= c) void'(rq.pop_front());
                if (start && !eb) begin
                    busy_from = c + 1;
                    done_cycle = (row_count == 0) ? c + 1 : BIG;
                    maddr = base_addr;
                    mrc = row_count;
                    macc = 0;
                    last_emit = c;
                end
                if (in_valid && er) begin
                    t0 = (last_emit + 1 > c + 1) ? last_emit + 1 : c + 1;
                    row = in_data;
                    for (int k = 0; k < W; k++) begin
                        wq.push_back('{t0 + k, maddr, row[k*SDW +: SDW]});
                        maddr = maddr + 1'b1;
                    end
                    rq.push_back('{c, t0});
                    last_emit = t0 + W - 1;
                    macc++;
                    if (macc == mrc) done_cycle = last_emit + 1;
                end
            end
        end else if (rst) begin
            armed = 1;
        end
    end

    function automatic logic [ROW_W-1:0] rand_row();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic clear_logs();
        log_n = 0;
        wen_cnt = 0;
        busy_cnt = 0;
    endtask

    task automatic run_job(input logic [AW-1:0] base, input logic [CW-1:0] rc, input int prob,
                           input bit fixed, input logic [ROW_W-1:0] fd);
        int d0, n;
        d0 = done_seen;
        n = 0;
        @(posedge clk); #1;
        clear_logs();
        start = 1'b1;
        base_addr = base;
        row_count = rc;
        @(posedge clk); #1;
        start = 1'b0;
        while (done_seen == d0 && n < 3000) begin
            in_valid = ($urandom_range(0, 99) < prob);
            in_data = fixed ? fd : rand_row();
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        chk("job_done", done_seen - d0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int w0, d0, n;
        logic [ROW_W-1:0] lanes;
        logic [AW-1:0] wrap_a [4];
        logic [SDW-1:0] lit_d [4];

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_sram_wen", sram_wen, 0);
        chk("rst_sram_waddr", sram_waddr, 0);
        chk("rst_sram_wdata", sram_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        // Single row with lanes 1..8.
        for (int i = 0; i < AS; i++) lanes[i*ODW +: ODW] = 16'(i + 1);
        lit_d[0] = 32'h00020001; lit_d[1] = 32'h00040003;
        lit_d[2] = 32'h00060005; lit_d[3] = 32'h00080007;
        run_job(10'h010, 10'd1, 100, 1'b1, lanes);
        chk("lit_nwords", log_n, 4);
        for (int k = 0; k < 4; k++) begin
            chk("lit_addr", log_a[k], 10'h010 + k);
            chk("lit_data", log_d[k], lit_d[k]);
        end

        // Three rows, valid held: twelve gapless writes.
        run_job(10'h010, 10'd3, 100, 1'b0, '0);
        chk("b2b_nwords", log_n, 12);
        chk("b2b_span", log_c[11] - log_c[0], 11);
        for (int k = 0; k < 12; k++) chk("b2b_addr", log_a[k], 10'h010 + k);

        // Address wrap.
        wrap_a[0] = 10'h3FE; wrap_a[1] = 10'h3FF; wrap_a[2] = 10'h000; wrap_a[3] = 10'h001;
        run_job(10'h3FE, 10'd1, 100, 1'b0, '0);
        for (int k = 0; k < 4; k++) chk("wrap_addr", log_a[k], wrap_a[k]);

        // Empty job.
        run_job(10'h055, 10'd0, 100, 1'b0, '0);
        chk("zero_wen", wen_cnt, 0);
        chk("zero_busy", busy_cnt, 1);

        // Valid while idle does nothing.
        clear_logs();
        in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1 in_valid = 1'b0;
        chk("idle_wen", wen_cnt, 0);
        chk("idle_busy", busy_cnt, 0);
`ifdef QWB_ERR_EN
        chk("idle_err", err, 1);
`endif

        // Reset mid-job.
        d0 = done_seen;
        @(posedge clk); #1;
        clear_logs();
        start = 1'b1; base_addr = 10'h100; row_count = 10'd2;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        n = 0;
        while (wen_cnt < 5 && n < 100) begin
            in_data = rand_row();
            @(posedge clk); #1;
            n++;
        end
        chk("mid_reached5", wen_cnt >= 5, 1);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_wen", sram_wen, 0);
        chk("mid_rst_waddr", sram_waddr, 0);
        chk("mid_rst_wdata", sram_wdata, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 0);
        #1 rst = 1'b0;
        w0 = wen_cnt;
        repeat (20) @(posedge clk);
        #1;
        chk("mid_no_writes", wen_cnt, w0);
        chk("mid_no_done", done_seen, d0);
        run_job(10'h100, 10'd2, 70, 1'b0, '0);
        chk("mid_restart_words", log_n, 2 * W);

        // FIFO fill with a long job at full input rate.
        run_job(10'h200, 10'd8, 100, 1'b0, '0);
        chk("fill_words", wen_cnt, 8 * W);

        // Random jobs.
        for (int j = 0; j < 25; j++) begin
            run_job(AW'($urandom), CW'($urandom_range(0, 6)), 20 + 40 * $urandom_range(0, 2), 1'b0, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
